// File: rtl/modn_disp_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner:
// segment glyphs {g,f,e,d,c,b,a}, scan state type, index width helper.
package modn_disp_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  // Bits needed to hold a value in 0..n-1 (never less than one bit).
  function automatic int idx_width(input int n);
    for (int w = 1; w < 32; w++) begin
      if ((1 << w) >= n) return w;
    end
    return 32;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit value to seven-segment glyph decoder (0-9, A b C d E F).
module seg7_decode
  import modn_disp_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_digit)
      4'h0:    o_seg = SEG_0;
      4'h1:    o_seg = SEG_1;
      4'h2:    o_seg = SEG_2;
      4'h3:    o_seg = SEG_3;
      4'h4:    o_seg = SEG_4;
      4'h5:    o_seg = SEG_5;
      4'h6:    o_seg = SEG_6;
      4'h7:    o_seg = SEG_7;
      4'h8:    o_seg = SEG_8;
      4'h9:    o_seg = SEG_9;
      4'hA:    o_seg = SEG_A;
      4'hB:    o_seg = SEG_B;
      4'hC:    o_seg = SEG_C;
      4'hD:    o_seg = SEG_D;
      4'hE:    o_seg = SEG_E;
      4'hF:    o_seg = SEG_F;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/modn_scan_display.sv
// Time-multiplexed seven-segment driver with frame-aligned load/ack shadowing.
// Optional leading-zero blanking is enabled by defining LZB_EN.
module modn_scan_display
  import modn_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int BLANK_CYC  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    load,
  output logic                    load_ack,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int IW = idx_width(NUM_DIGITS);
  localparam int PW = idx_width(SCAN_DIV);
  localparam logic [IW-1:0] IDX_LAST    = IW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] PRESC_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] PRESC_BLANK = PW'(BLANK_CYC);

  logic [PW-1:0]             r_presc;
  logic [IW-1:0]             r_idx;
  scan_state_e               r_state;
  logic [4*NUM_DIGITS-1:0]   r_shadow;
  logic [4*NUM_DIGITS-1:0]   r_holding;
  logic                      r_pending;
  logic                      r_load_ack;
  logic                      r_frame_done;
  logic [6:0]                r_seg;
  logic [NUM_DIGITS-1:0]     r_an;

  logic [PW-1:0]             w_presc_next;
  logic [IW-1:0]             w_idx_next;
  scan_state_e               w_state_next;
  logic                      w_boundary;
  logic [NUM_DIGITS-1:0]     w_onehot;
  logic [3:0]                w_digit;
  logic [6:0]                w_glyph;
  logic                      w_blank_digit;
  logic [6:0]                w_seg_next;
  logic [NUM_DIGITS-1:0]     w_an_next;

  assign w_boundary = (r_presc == PRESC_LAST) && (r_idx == IDX_LAST);

  always_comb begin
    w_presc_next = r_presc + PW'(1);
    w_idx_next   = r_idx;
    if (r_presc == PRESC_LAST) begin
      w_presc_next = {PW{1'b0}};
      if (r_idx == IDX_LAST) begin
        w_idx_next = {IW{1'b0}};
      end else begin
        w_idx_next = r_idx + IW'(1);
      end
    end else begin
      w_idx_next = r_idx;
    end
  end

  // State tracks the prescaler position within the slot it is registered with.
  always_comb begin
    w_state_next = DRIVE;
    if (w_presc_next < PRESC_BLANK) begin
      w_state_next = BLANK;
    end else begin
      w_state_next = DRIVE;
    end
  end

  always_comb begin
    w_onehot = {NUM_DIGITS{1'b0}};
    w_digit  = 4'h0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == IW'(k)) begin
        w_onehot[k] = 1'b1;
        w_digit     = r_shadow[4*k +: 4];
      end else begin
        w_onehot[k] = 1'b0;
      end
    end
  end

`ifdef LZB_EN
  logic [NUM_DIGITS-1:0] w_lz;

  // w_lz[k]: digit k and every digit above it are zero; digit 0 is never blanked.
  always_comb begin
    w_lz = {NUM_DIGITS{1'b0}};
    w_lz[NUM_DIGITS-1] = (r_shadow[4*(NUM_DIGITS-1) +: 4] == 4'h0);
    for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
      w_lz[k] = (r_shadow[4*k +: 4] == 4'h0) && w_lz[k+1];
    end
    w_lz[0] = 1'b0;
  end

  assign w_blank_digit = |(w_lz & w_onehot);
`else
  assign w_blank_digit = 1'b0;
`endif

  seg7_decode u_decode (
    .i_digit (w_digit),
    .o_seg   (w_glyph)
  );

  always_comb begin
    w_seg_next = SEG_BLANK;
    w_an_next  = {NUM_DIGITS{1'b0}};
    case (r_state)
      BLANK: begin
        w_seg_next = SEG_BLANK;
        w_an_next  = {NUM_DIGITS{1'b0}};
      end
      DRIVE: begin
        w_an_next = w_onehot;
        if (w_blank_digit) begin
          w_seg_next = SEG_BLANK;
        end else begin
          w_seg_next = w_glyph;
        end
      end
      default: begin
        w_seg_next = SEG_BLANK;
        w_an_next  = {NUM_DIGITS{1'b0}};
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_presc <= {PW{1'b0}};
      r_idx   <= {IW{1'b0}};
      r_state <= BLANK;
      r_seg   <= SEG_BLANK;
      r_an    <= {NUM_DIGITS{1'b0}};
    end else begin
      r_presc <= w_presc_next;
      r_idx   <= w_idx_next;
      r_state <= w_state_next;
      r_seg   <= w_seg_next;
      r_an    <= w_an_next;
    end
  end

  // A load on the boundary edge lands in holding and stays pending for the next frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shadow     <= {(4*NUM_DIGITS){1'b0}};
      r_holding    <= {(4*NUM_DIGITS){1'b0}};
      r_pending    <= 1'b0;
      r_load_ack   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_boundary;
      r_load_ack   <= w_boundary && r_pending;
      if (w_boundary && r_pending) begin
        r_shadow <= r_holding;
      end
      if (load) begin
        r_holding <= digits_in;
        r_pending <= 1'b1;
      end else if (w_boundary) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign seg        = r_seg;
  assign an         = r_an;
  assign load_ack   = r_load_ack;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_modn_scan_display.sv
// Directed bench for modn_scan_display with NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2.
module tb_modn_scan_display;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits_in = 16'h0000;
  logic        load_ack;
  logic        frame_done;
  logic [6:0]  seg;
  logic [3:0]  an;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  modn_scan_display #(
    .NUM_DIGITS (4),
    .SCAN_DIV   (8),
    .BLANK_CYC  (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .digits_in  (digits_in),
    .load       (load),
    .load_ack   (load_ack),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  4'hF: return 7'h71;
      default: return 7'h00;
    endcase
  endfunction

  // Expected {an, seg} after clock edge n (n>=1) counted from reset release.
  function automatic logic [10:0] exp_out(input int n, input logic [15:0] sh);
    int p;
    int s;
    logic [15:0] hi;
    p  = (n - 1) % 8;
    s  = ((n - 1) / 8) % 4;
    if (p < 2) return 11'h000;
    hi = sh >> (4 * s);
`ifdef LZB_EN
    if (s > 0 && hi == 16'h0000) return {4'(1 << s), 7'h00};
`endif
    return {4'(1 << s), glyph(hi[3:0])};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    logic [12:0] ex;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({an, seg, frame_done, load_ack} !== 13'h0) begin
      n_bad++;
      $display("FAIL reset_state got=%h exp=%h", {an, seg, frame_done, load_ack}, 13'h0);
    end
    reset = 1'b1;
    cyc   = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      ex = {exp_out(cyc, 16'h0000), (cyc % 32) == 0, 1'b0};
      n_cmp++;
      if ({an, seg, frame_done, load_ack} !== ex) begin
        n_bad++;
        $display("FAIL idle_scan cyc=%0d got=%h exp=%h", cyc, {an, seg, frame_done, load_ack}, ex);
      end
    end
  endtask

  task automatic test_load();
    logic [12:0] ex;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 32; i++) begin
        load = (f == 0) && (i == 10);
        digits_in = 16'h4321;
        tick();
        ex = {exp_out(cyc, (f == 0) ? 16'h0000 : 16'h4321), (cyc % 32) == 0, (f == 0) && (i == 31)};
        n_cmp++;
        if ({an, seg, frame_done, load_ack} !== ex) begin
          n_bad++;
          $display("FAIL load_4321 cyc=%0d got=%h exp=%h", cyc, {an, seg, frame_done, load_ack}, ex);
        end
      end
    end
    load = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [12:0] ex;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 32; i++) begin
        load = (f == 0) && (i == 5 || i == 12);
        digits_in = (i < 8) ? 16'h1111 : 16'h2222;
        tick();
        ex = {exp_out(cyc, (f == 0) ? 16'h4321 : 16'h2222), (cyc % 32) == 0, (f == 0) && (i == 31)};
        n_cmp++;
        if ({an, seg, frame_done, load_ack} !== ex) begin
          n_bad++;
          $display("FAIL back_to_back cyc=%0d got=%h exp=%h", cyc, {an, seg, frame_done, load_ack}, ex);
        end
      end
    end
    load = 1'b0;
  endtask

  task automatic test_boundary_load();
    logic [12:0] ex;
    logic [15:0] sh;
    for (int f = 0; f < 3; f++) begin
      sh = (f == 0) ? 16'h2222 : ((f == 1) ? 16'h5555 : 16'h9999);
      for (int i = 0; i < 32; i++) begin
        load = (f == 0) && (i == 4 || i == 31);
        digits_in = (i == 31) ? 16'h9999 : 16'h5555;
        tick();
        ex = {exp_out(cyc, sh), (cyc % 32) == 0, (f < 2) && (i == 31)};
        n_cmp++;
        if ({an, seg, frame_done, load_ack} !== ex) begin
          n_bad++;
          $display("FAIL boundary_load cyc=%0d got=%h exp=%h", cyc, {an, seg, frame_done, load_ack}, ex);
        end
      end
    end
    load = 1'b0;
  endtask

  task automatic test_hex_glyphs();
    logic [12:0] ex;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 32; i++) begin
        load = (f == 0) && (i == 3);
        digits_in = 16'hFA0A;
        tick();
        ex = {exp_out(cyc, (f == 0) ? 16'h9999 : 16'hFA0A), (cyc % 32) == 0, (f == 0) && (i == 31)};
        n_cmp++;
        if ({an, seg, frame_done, load_ack} !== ex) begin
          n_bad++;
          $display("FAIL hex_glyph cyc=%0d got=%h exp=%h", cyc, {an, seg, frame_done, load_ack}, ex);
        end
      end
    end
    load = 1'b0;
  endtask

  task automatic test_leading_zero();
    logic [12:0] ex;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 32; i++) begin
        load = (f == 0) && (i == 0);
        digits_in = 16'h0030;
        tick();
        ex = {exp_out(cyc, (f == 0) ? 16'hFA0A : 16'h0030), (cyc % 32) == 0, (f == 0) && (i == 31)};
        n_cmp++;
        if ({an, seg, frame_done, load_ack} !== ex) begin
          n_bad++;
          $display("FAIL leading_zero cyc=%0d got=%h exp=%h", cyc, {an, seg, frame_done, load_ack}, ex);
        end
      end
    end
    load = 1'b0;
  endtask

  task automatic test_reset_midframe();
    logic [12:0] ex;
    // Run into slot 2, prescaler 5, with a load pending.
    for (int i = 0; i < 21; i++) begin
      load = (i == 2);
      digits_in = 16'h7777;
      tick();
      ex = {exp_out(cyc, 16'h0030), (cyc % 32) == 0, 1'b0};
      n_cmp++;
      if ({an, seg, frame_done, load_ack} !== ex) begin
        n_bad++;
        $display("FAIL pre_reset cyc=%0d got=%h exp=%h", cyc, {an, seg, frame_done, load_ack}, ex);
      end
    end
    load  = 1'b0;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({an, seg, frame_done, load_ack} !== 13'h0) begin
      n_bad++;
      $display("FAIL async_reset got=%h exp=%h", {an, seg, frame_done, load_ack}, 13'h0);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    cyc   = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      ex = {exp_out(cyc, 16'h0000), (cyc % 32) == 0, 1'b0};
      n_cmp++;
      if ({an, seg, frame_done, load_ack} !== ex) begin
        n_bad++;
        $display("FAIL post_reset cyc=%0d got=%h exp=%h", cyc, {an, seg, frame_done, load_ack}, ex);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_back_to_back();
    test_boundary_load();
    test_hex_glyphs();
    test_leading_zero();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
